// File: rtl/histogram_chunk_streamer_if.sv
// Handshake bundle between the histogram chunk streamer, the histogram RAM read port
// and the threshold chunk scanner.
interface histogram_chunk_streamer_if #(
  parameter int BIN_W      = 16,
  parameter int CHUNK_BINS = 8
);
  logic                        start;
  logic                        abort;
  logic                        rd_en;
  logic [7:0]                  rd_addr;
  logic [BIN_W-1:0]            rd_data;
  logic                        chunk_valid;
  logic                        chunk_ready;
  logic [CHUNK_BINS*BIN_W-1:0] histogram_chunk;
  logic [7:0]                  bin_index;
  logic                        last;
  logic                        busy;
  logic                        done;

  modport master (
    input  start, abort, rd_data, chunk_ready,
    output rd_en, rd_addr, chunk_valid, histogram_chunk, bin_index, last, busy, done
  );

  modport slave (
    output start, abort, rd_data, chunk_ready,
    input  rd_en, rd_addr, chunk_valid, histogram_chunk, bin_index, last, busy, done
  );
endinterface

// File: rtl/histogram_chunk_streamer.sv
// Walks the histogram RAM from the top bins downward, packing CHUNK_BINS bins per chunk
// and handing each chunk plus its base bin index to the threshold scanner.
//
// state   | meaning
// IDLE    | waiting for start
// FETCH   | issuing CHUNK_BINS ascending reads from base
// DRAIN   | capturing the final read datum
// PRESENT | chunk valid, waiting for ready
// DONE    | one-cycle done pulse after the base-0 chunk is accepted
module histogram_chunk_streamer #(
  parameter int N_BINS     = 256,
  parameter int BIN_W      = 16,
  parameter int CHUNK_BINS = 8
) (
  input logic clk,
  input logic rst,
  histogram_chunk_streamer_if.master bus
);
  localparam int                SLOT_W     = (CHUNK_BINS > 1) ? $clog2(CHUNK_BINS) : 1;
  localparam logic [7:0]        FIRST_BASE = 8'(N_BINS - CHUNK_BINS);
  localparam logic [7:0]        BASE_STEP  = 8'(CHUNK_BINS);
  localparam logic [SLOT_W-1:0] LAST_SLOT  = SLOT_W'(CHUNK_BINS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

  state_t                      state, state_nxt;
  logic [7:0]                  base;
  logic [SLOT_W-1:0]           slot;
  logic [SLOT_W-1:0]           cap_slot;
  logic                        cap_pending;
  logic [CHUNK_BINS*BIN_W-1:0] chunk;

  logic load_first, load_next, slot_inc;
  logic rd_en, chunk_valid, done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_first  = 1'b0;
    load_next   = 1'b0;
    slot_inc    = 1'b0;
    rd_en       = 1'b0;
    chunk_valid = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nxt  = FETCH;
          load_first = 1'b1;
        end
      end
      FETCH: begin
        rd_en    = 1'b1;
        slot_inc = 1'b1;
        if (bus.abort)              state_nxt = IDLE;
        else if (slot == LAST_SLOT) state_nxt = DRAIN;
      end
      DRAIN: begin
        state_nxt = bus.abort ? IDLE : PRESENT;
      end
      PRESENT: begin
        chunk_valid = 1'b1;
        // abort takes priority over a simultaneous handshake
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (bus.chunk_ready) begin
          if (base == '0) begin
            state_nxt = DONE;
          end else begin
            state_nxt = FETCH;
            load_next = 1'b1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM data trails the strobe by one cycle; remember which slot it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base        <= '0;
      slot        <= '0;
      cap_slot    <= '0;
      cap_pending <= 1'b0;
      chunk       <= '0;
    end else begin
      cap_pending <= rd_en;
      cap_slot    <= slot;
      if (load_first) begin
        base <= FIRST_BASE;
        slot <= '0;
      end else if (load_next) begin
        base <= base - BASE_STEP;
        slot <= '0;
      end else if (slot_inc) begin
        slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
      end
      // data landing after an abort finds the FSM in IDLE and is dropped
      if (cap_pending && (state == FETCH || state == DRAIN))
        chunk[cap_slot*BIN_W +: BIN_W] <= bus.rd_data;
    end
  end

  assign bus.rd_en           = rd_en;
  assign bus.rd_addr         = rd_en ? (base + 8'(slot)) : '0;
  assign bus.chunk_valid     = chunk_valid;
  assign bus.histogram_chunk = chunk;
  assign bus.bin_index       = base;
  assign bus.last            = chunk_valid && (base == '0);
  assign bus.busy            = (state != IDLE);
  assign bus.done            = done;
endmodule

// File: tb/tb_histogram_chunk_streamer.sv
// Randomized bench for histogram_chunk_streamer: a RAM model and a timeline model of the
// scan check every output each cycle, plus literal checks on the directed scenarios.
module tb_histogram_chunk_streamer;
  localparam int N_BINS = 256;
  localparam int BIN_W  = 16;
  localparam int CB     = 8;
  localparam int CW     = CB * BIN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  histogram_chunk_streamer_if #(.BIN_W(BIN_W), .CHUNK_BINS(CB)) bus ();

  histogram_chunk_streamer #(.N_BINS(N_BINS), .BIN_W(BIN_W), .CHUNK_BINS(CB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [BIN_W-1:0] mem [N_BINS];

  // synchronous-read RAM; returns junk on cycles without a read
  always @(posedge clk) bus.rd_data <= bus.rd_en ? mem[bus.rd_addr] : BIN_W'($urandom);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] model_chunk(input int b);
    logic [CW-1:0] r;
    r = '0;
    for (int i = 0; i < CB; i++) r[i*BIN_W +: BIN_W] = mem[b + i];
    return r;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // ---------------- timeline model + compare process ----------------
  int cyc = 0;
  bit scanning = 0;
  int trig = -1000;
  int mbase = 0;
  int done_cyc = -1;

  int hs_idx[$];
  int rd_log[$];
  int done_cnt, last_cnt, start_cyc, first_rd_cyc, first_valid_cyc;
  logic [CW-1:0] first_chunk;

  task automatic clear_logs();
    hs_idx.delete();
    rd_log.delete();
    done_cnt = 0;
    last_cnt = 0;
    start_cyc = -1;
    first_rd_cyc = -1;
    first_valid_cyc = -1;
    first_chunk = '0;
  endtask

  always @(negedge clk) begin
    bit e_rd, e_valid, e_done, e_busy;
    int rel;
    cyc++;
    if (rst) begin
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_rd_addr", bus.rd_addr, 0);
      check("rst_valid", bus.chunk_valid, 0);
      check("rst_chunk", bus.histogram_chunk, 0);
      check("rst_index", bus.bin_index, 0);
      check("rst_last", bus.last, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      scanning = 0;
      done_cyc = -1;
    end else begin
      rel     = cyc - trig;
      e_rd    = scanning && rel >= 1 && rel <= CB;
      e_valid = scanning && rel >= CB + 2;
      e_done  = (cyc == done_cyc);
      e_busy  = scanning || e_done;
      check("rd_en", bus.rd_en, e_rd);
      check("chunk_valid", bus.chunk_valid, e_valid);
      check("busy", bus.busy, e_busy);
      check("done", bus.done, e_done);
      if (e_rd && bus.rd_en) check("rd_addr", bus.rd_addr, mbase + rel - 1);
      if (e_valid && bus.chunk_valid) begin
        check("chunk", bus.histogram_chunk, model_chunk(mbase));
        check("bin_index", bus.bin_index, mbase);
        check("last", bus.last, (mbase == 0));
      end else begin
        check("last_unqualified", bus.last, 0);
      end

      if (bus.rd_en) begin
        rd_log.push_back(int'(bus.rd_addr));
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (bus.chunk_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.done) done_cnt++;
      if (bus.chunk_valid && bus.chunk_ready && !bus.abort) begin
        if (hs_idx.size() == 0) first_chunk = bus.histogram_chunk;
        hs_idx.push_back(int'(bus.bin_index));
        if (bus.last) last_cnt++;
      end

      if (scanning && bus.abort) begin
        scanning = 0;
      end else if (scanning && e_valid && bus.chunk_ready) begin
        if (mbase == 0) begin
          scanning = 0;
          done_cyc = cyc + 1;
        end else begin
          mbase = mbase - CB;
          trig  = cyc;
        end
      end else if (!scanning && !e_done && bus.start && !bus.abort) begin
        scanning = 1;
        mbase    = N_BINS - CB;
        trig     = cyc;
        if (start_cyc < 0) start_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus ----------------
  int hold_cnt = 0;
  bit rand_ready = 0;

  task automatic step(input bit st, input bit ab);
    @(posedge clk);
    #1;
    bus.start = st;
    bus.abort = ab;
    if (hold_cnt > 0) begin
      bus.chunk_ready = 1'b0;
      hold_cnt--;
    end else begin
      bus.chunk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic wait_idle(input int limit, input string tag);
    int n;
    n = 0;
    step(0, 0);
    while (bus.busy && n < limit) begin
      step(0, 0);
      n++;
    end
    checks++;
    if (bus.busy) begin
      errors++;
      $display("FAIL %s_timeout: busy=%0d after %0d cycles, expected 0", tag, bus.busy, n);
    end
  endtask

  task automatic wait_for_chunk(input int idx, input int limit, input string tag);
    int n;
    n = 0;
    while (!(bus.chunk_valid && bus.bin_index == 8'(idx)) && n < limit) begin
      step(0, 0);
      n++;
    end
    check({tag, "_found"}, bus.chunk_valid && bus.bin_index == 8'(idx), 1);
  endtask

  task automatic randomize_mem();
    for (int a = 0; a < N_BINS; a++) mem[a] = BIN_W'($urandom);
  endtask

  initial begin
    int n;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.chunk_ready = 1'b0;
    clear_logs();
    for (int a = 0; a < N_BINS; a++) mem[a] = BIN_W'(a);

    repeat (3) step(0, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_chunk", bus.histogram_chunk, 0);
    rst = 1'b0;
    repeat (3) step(0, 0);

    // full scan with RAM[a]=a, consumer always ready
    clear_logs();
    step(1, 0);
    wait_idle(1000, "full_scan");
    check("full_chunks", hs_idx.size(), 32);
    check("full_idx0", qget(hs_idx, 0), 248);
    check("full_idx1", qget(hs_idx, 1), 240);
    check("full_idx31", qget(hs_idx, 31), 0);
    check("first_chunk_lo", first_chunk[15:0], 16'h00F8);
    check("first_chunk_hi", first_chunk[127:112], 16'h00FF);
    check("full_last_cnt", last_cnt, 1);
    check("full_done_cnt", done_cnt, 1);
    check("lat_first_rd", first_rd_cyc - start_cyc, 1);
    check("lat_first_valid", first_valid_cyc - start_cyc, 10);
    check("rd_addr_0", qget(rd_log, 0), 248);
    check("rd_addr_7", qget(rd_log, 7), 255);
    check("rd_count", rd_log.size(), 256);

    // backpressure: ready low S+1..S+14, chunk 248 waits five valid cycles
    clear_logs();
    step(1, 0);
    hold_cnt = 14;
    wait_idle(1000, "backpressure");
    check("bp_first_valid", first_valid_cyc - start_cyc, 10);
    check("bp_idx0", qget(hs_idx, 0), 248);
    check("bp_next_fetch", qget(rd_log, 8), 240);
    check("bp_rd_count", rd_log.size(), 256);
    check("bp_chunks", hs_idx.size(), 32);

    // abort while chunk 232 is presented (ready high too: abort wins)
    randomize_mem();
    clear_logs();
    step(1, 0);
    wait_for_chunk(232, 500, "abort");
    bus.abort = 1'b1;
    step(0, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_valid", bus.chunk_valid, 0);
    check("abort_done", bus.done, 0);
    repeat (5) step(0, 0);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_chunks", hs_idx.size(), 2);
    clear_logs();
    step(1, 0);
    wait_idle(1000, "restart");
    check("restart_idx0", qget(hs_idx, 0), 248);
    check("restart_chunks", hs_idx.size(), 32);
    check("restart_done_cnt", done_cnt, 1);

    // start pulse during the fetch of chunk 240 is ignored
    clear_logs();
    step(1, 0);
    n = 0;
    while (!(bus.rd_en && bus.rd_addr == 8'd240) && n < 500) begin
      step(0, 0);
      n++;
    end
    check("busy_start_found", bus.rd_en && bus.rd_addr == 8'd240, 1);
    bus.start = 1'b1;
    wait_idle(1000, "busy_start");
    check("busy_start_chunks", hs_idx.size(), 32);
    check("busy_start_idx1", qget(hs_idx, 1), 240);
    check("busy_start_done_cnt", done_cnt, 1);

    // random starts, aborts and backpressure, checked by the model each cycle
    randomize_mem();
    rand_ready = 1;
    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
    rand_ready = 0;
    wait_idle(1000, "random_drain");

    // reset asserted in DRAIN (cycle S+9)
    clear_logs();
    step(1, 0);
    repeat (9) step(0, 0);
    check("drain_busy_before_rst", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_rd_en", bus.rd_en, 0);
    check("mid_rst_valid", bus.chunk_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_chunk", bus.histogram_chunk, 0);
    check("mid_rst_index", bus.bin_index, 0);
    step(0, 0);
    rst = 1'b0;
    repeat (20) step(0, 0);
    check("post_rst_idle", bus.busy, 0);
    check("post_rst_done_cnt", done_cnt, 0);
    clear_logs();
    step(1, 0);
    wait_idle(1000, "post_rst_scan");
    check("post_rst_chunks", hs_idx.size(), 32);
    check("post_rst_idx0", qget(hs_idx, 0), 248);

    repeat (3) step(0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    errors++;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/histogram_chunk_streamer.md
Name: histogram_chunk_streamer

Overview:
- Producer side of the histogram chunk interface: walks the histogram RAM, packs 8 consecutive 16-bit bins into one 128-bit chunk, and presents each chunk with its absolute base bin index to the threshold chunk scanner.
- Chunks are streamed from the highest bins downward, so the scanner sees the brightest bins first.
- Sits between the histogram accumulator RAM read port and the threshold logic.
- Supports early abort once a threshold has been found.

Parameters:
- N_BINS, 256, total histogram bins; multiple of CHUNK_BINS, at most 256.
- BIN_W, 16, bits per bin.
- CHUNK_BINS, 8, bins per chunk.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset, asynchronous, active-high
- i_start  input  1  single-cycle request to begin a scan; ignored unless idle
- i_abort  input  1  terminate the scan in progress
- o_rd_en  output  1  RAM read strobe
- o_rd_addr  output  8  RAM bin address
- i_rd_data  input  BIN_W  RAM read data, valid the cycle after o_rd_en
- o_chunk_valid  output  1  chunk and index valid
- i_chunk_ready  input  1  consumer accepts chunk
- o_histogram_chunk  output  CHUNK_BINS*BIN_W  packed bins; bin i at bits [i*BIN_W +: BIN_W]
- o_bin_index  output  8  absolute index of bin 0 of the chunk
- o_last  output  1  chunk is the final one (base index 0); qualified by o_chunk_valid
- o_busy  output  1  scan in progress
- o_done  output  1  one-cycle pulse after the final chunk is accepted

Behaviour:
- Reset behaviour:
  - Asynchronous reset forces state IDLE.
  - All outputs go to 0, including the chunk register, o_bin_index and the base counter.
  - Reset mid-scan discards all progress, with no o_done.
- States:
  - IDLE -> FETCH on i_start.
  - FETCH issues CHUNK_BINS reads, then -> DRAIN.
  - DRAIN captures the final read datum, then -> PRESENT.
  - PRESENT holds until valid & ready. It then goes to FETCH for the next chunk, or to DONE if the chunk was the last one.
  - DONE pulses o_done, then -> IDLE.
- Chunk order:
  - The first base index is N_BINS-CHUNK_BINS (248 by default).
  - Each later base is the previous base minus CHUNK_BINS.
  - The last base is 0.
- Reads within a chunk:
  - Ascending addresses base..base+CHUNK_BINS-1, one per cycle, with o_rd_en high for exactly CHUNK_BINS consecutive cycles.
  - Data for address base+i lands in chunk slot i on the edge after it appears on i_rd_data.
- Timing, with i_start sampled in cycle S:
  - o_rd_en is high in cycles S+1..S+8.
  - o_chunk_valid first rises in S+10.
- Handshake:
  - While valid, o_histogram_chunk, o_bin_index and o_last stay stable until valid & ready.
  - After a handshake, o_chunk_valid drops the next cycle and the next chunk's FETCH begins that same cycle. There is no prefetch.
- o_last is high exactly when o_bin_index == 0 and valid.
- o_done is high the cycle after the final handshake, for one cycle.
- o_busy is high in every state except IDLE, including DONE.
- Abort:
  - i_abort in FETCH, DRAIN or PRESENT forces IDLE on the next edge.
  - o_rd_en and o_chunk_valid deassert and no o_done is issued.
  - Read data arriving after the abort is ignored.
- Simultaneous events:
  - i_abort with valid & ready in the same cycle: abort wins.
  - i_start with i_abort in IDLE: start ignored.
  - i_start while busy: ignored, no restart.
  - i_start in the cycle o_done is high: ignored, because the block is not yet idle.
- Width and arithmetic:
  - The base counter is 8 bits and is computed only from valid bases, so the decrement never wraps below 0.
  - o_rd_addr = base + slot, 8 bits, never exceeding N_BINS-1.

Test Plan:
- Full scan: RAM[a]=a, consumer ready always.
  - Start gives 32 chunks with indices 248, 240, ..., 0.
  - First chunk bits[15:0]=0x00F8 and bits[127:112]=0x00FF.
  - o_last is set only on index 0, and o_done pulses once.
- Latency: start in cycle S.
  - o_rd_en high S+1..S+8 with addresses 248..255.
  - o_chunk_valid in S+10.
- Backpressure: hold i_chunk_ready low 5 cycles on chunk 248.
  - Chunk and index stay stable, with no further o_rd_en until the handshake.
  - The next fetch starts at address 240.
- Abort: assert i_abort while chunk 232 is presented.
  - Next cycle: o_busy=0, o_chunk_valid=0, no o_done.
  - A fresh start resumes from 248.
- Start while busy: pulse i_start during the FETCH of chunk 240.
  - The sequence is unchanged and total chunks stay at 32.
- Reset mid-DRAIN: assert i_rst.
  - All outputs are 0 immediately.
  - After release the block idles until i_start.
